char_writer: RTL and testbench
==============================

CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter DEPTH, default 8: number of character slots written, 1..32.
REQ-002 Parameter ADDR_W, default 5: memory address width.
REQ-003 CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESETn  input  1  reset, asynchronous, active-low.
REQ-005 SW_CHAR  input  8  ASCII code presented on switches; asynchronous to CLOCK.
REQ-006 WR_KEYn  input  1  write pushbutton, active-low, asynchronous.
REQ-007 CLR_KEYn  input  1  clear pushbutton, active-low, asynchronous.
REQ-008 mem_addr  output  ADDR_W  write address to character memory.
REQ-009 mem_data  output  8  ASCII character to write.
REQ-010 mem_wren  output  1  memory write enable, one-cycle pulse.
REQ-011 wr_count  output  6  number of slots written, 0..DEPTH.
REQ-012 full  output  1  high when wr_count == DEPTH.
REQ-013 err  output  1  sticky: a press carried an unsupported character.
REQ-014 ovf  output  1  sticky: a write press occurred while full.

Function
REQ-015 WR_KEYn, CLR_KEYn and SW_CHAR SHALL each pass through a two-flop synchronizer before use.
REQ-016 A press SHALL be the synchronized 1->0 transition of a key, yielding a one-cycle pulse; a held key yields exactly one pulse.
REQ-017 Supported characters SHALL be exactly 65 'A', 98 'b', 67 'C', 100 'd', 69 'E', 70 'F', 103 'g' and 104 'h'; all other codes are unsupported.
REQ-018 FSM states SHALL be IDLE, WRITE and FULL.
REQ-019 IDLE + write pulse + supported char: latch char into mem_data, drive mem_addr = wr_ptr, go to WRITE.
REQ-020 IDLE + write pulse + unsupported char: set err, perform no write, stay in IDLE.
REQ-021 WRITE SHALL assert mem_wren for exactly one cycle, then increment wr_ptr and wr_count by 1; next state is FULL if the new wr_count == DEPTH, otherwise IDLE.
REQ-022 Latency SHALL be: mem_wren high in the second cycle after the write pulse cycle.
REQ-023 mem_addr SHALL equal wr_ptr zero-extended to ADDR_W, taking values 0..DEPTH-1 only; wr_ptr never wraps.
REQ-024 FULL + write pulse: set ovf, no write, stay in FULL; err is not evaluated in FULL.
REQ-025 A clear pulse in any state SHALL zero wr_ptr, wr_count, err and ovf and go to IDLE next cycle; memory contents are not erased.
REQ-026 A clear pulse coinciding with a write pulse, or with WRITE state, SHALL take priority: any pending mem_wren is suppressed and no counter increments.
REQ-027 mem_wren SHALL never be high in two consecutive cycles.
REQ-028 full SHALL be a registered output consistent with wr_count in the same cycle.

Reset
REQ-029 RESETn low SHALL immediately force state IDLE, mem_wren 0, mem_addr 0, mem_data 0, wr_count 0, full 0, err 0, ovf 0, and all synchronizer flops to the key-released level (1) and 0 for SW_CHAR.
REQ-030 Reset asserted during WRITE SHALL cancel the write; release SHALL create no false press pulse.

Structure
REQ-031 The eight supported ASCII codes and the state encoding SHALL be constants in a shared display package, also used by the HEX decoder.
REQ-032 The synchronizer-plus-falling-edge detector SHALL be one sub-module, key_press, instantiated once per key.

Verification
REQ-033 Reset; write press with SW_CHAR=65 -> mem_wren one cycle, mem_addr=0, mem_data=65; wr_count=1.
REQ-034 Eight presses of 65,98,67,100,69,70,103,104 -> addresses 0..7 written in order, full=1 after the 8th; a 9th press -> no mem_wren, ovf=1.
REQ-035 Press with SW_CHAR=66 -> no mem_wren, err=1, wr_count unchanged; a following press with 67 writes normally and err stays 1.
REQ-036 Clear and write pressed in the same synchronized cycle at wr_count=3 -> no mem_wren; wr_count=0, err=0, ovf=0.
REQ-037 RESETn pulsed low during WRITE -> outputs zero immediately; no mem_wren after release; key held low across reset release -> no pulse.

Source files
------------

// File: rtl/char_writer_pkg.sv
// char_writer_pkg
// Shared display constants: the eight ASCII codes that the character writer
// accepts (the HEX decoder uses the same set) and the writer FSM encoding.
// No ports; provides constants and the is_supported() helper.
package char_writer_pkg;

   localparam logic [7:0] CH_A = 8'd65;   // 'A'
   localparam logic [7:0] CH_B = 8'd98;   // 'b'
   localparam logic [7:0] CH_C = 8'd67;   // 'C'
   localparam logic [7:0] CH_D = 8'd100;  // 'd'
   localparam logic [7:0] CH_E = 8'd69;   // 'E'
   localparam logic [7:0] CH_F = 8'd70;   // 'F'
   localparam logic [7:0] CH_G = 8'd103;  // 'g'
   localparam logic [7:0] CH_H = 8'd104;  // 'h'

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   function automatic logic is_supported(input logic [7:0] c);
      case (c)
         CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/char_writer_key_press.sv
// key_press
// Two-flop synchronizer plus falling-edge detector for an active-low
// pushbutton. Produces a single-cycle press pulse per press, however long
// the key is held.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   key_ni   raw active-low key, asynchronous to clk_i
//   press_o  one-cycle pulse on the synchronized 1->0 transition
module key_press (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic press_o
);

   logic       sync1_q;
   logic       sync2_q;
   logic       prev_q;
   logic [2:0] arm_q;

   // arm_q fills with ones as real key samples displace the reset values in
   // the pipeline; until prev_q holds a genuine sample no edge is reported,
   // so a key held low across reset release does not look like a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         arm_q   <= 3'b000;
      end else begin
         sync1_q <= key_ni;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         arm_q   <= {arm_q[1:0], 1'b1};
      end
   end

   assign press_o = arm_q[2] & prev_q & ~sync2_q;

endmodule

// File: rtl/char_writer.sv
// char_writer
// Writes ASCII characters chosen on switches into consecutive slots of a
// character memory, one per write-key press, with clear, error and overflow
// tracking.
// Ports:
//   CLOCK     system clock
//   RESETn    asynchronous active-low reset
//   SW_CHAR   ASCII code on switches (asynchronous)
//   WR_KEYn   write pushbutton, active-low (asynchronous)
//   CLR_KEYn  clear pushbutton, active-low (asynchronous)
//   mem_addr  memory write address
//   mem_data  memory write data
//   mem_wren  memory write enable, single-cycle pulse
//   wr_count  slots written, 0..DEPTH
//   full      wr_count == DEPTH
//   err       sticky: unsupported character pressed
//   ovf       sticky: write pressed while full
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a press; slots remain
// ST_WRITE | character and address latched; write strobe issued on exit
// ST_FULL  | DEPTH slots written; further write presses only set ovf
module char_writer
   import char_writer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 5
) (
   input  logic              CLOCK,
   input  logic              RESETn,
   input  logic [7:0]        SW_CHAR,
   input  logic              WR_KEYn,
   input  logic              CLR_KEYn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_wren,
   output logic [5:0]        wr_count,
   output logic              full,
   output logic              err,
   output logic              ovf
);

   logic              wr_press;
   logic              clr_press;
   logic [7:0]        sw_sync1_q, sw_sync2_q;

   logic [1:0]        state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [5:0]        cnt_inc;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              wren_q, wren_d;
   logic              full_q, full_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;

   key_press u_wr_key (
      .clk_i   (CLOCK),
      .rst_ni  (RESETn),
      .key_ni  (WR_KEYn),
      .press_o (wr_press)
   );

   key_press u_clr_key (
      .clk_i   (CLOCK),
      .rst_ni  (RESETn),
      .key_ni  (CLR_KEYn),
      .press_o (clr_press)
   );

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         sw_sync1_q <= 8'd0;
         sw_sync2_q <= 8'd0;
      end else begin
         sw_sync1_q <= SW_CHAR;
         sw_sync2_q <= sw_sync1_q;
      end
   end

   // The write pointer always equals the count of slots written, so one
   // counter serves both; the address is only captured while cnt < DEPTH,
   // which keeps mem_addr within 0..DEPTH-1.
   assign cnt_inc = cnt_q + 6'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wren_d  = 1'b0;
      full_d  = full_q;
      err_d   = err_q;
      ovf_d   = ovf_q;

      if (clr_press) begin
         // Clear wins over a coincident write press and over a pending strobe.
         state_d = ST_IDLE;
         cnt_d   = 6'd0;
         addr_d  = '0;
         full_d  = 1'b0;
         err_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wr_press) begin
                  if (is_supported(sw_sync2_q)) begin
                     data_d  = sw_sync2_q;
                     addr_d  = ADDR_W'(cnt_q);
                     state_d = ST_WRITE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               wren_d  = 1'b1;
               cnt_d   = cnt_inc;
               full_d  = (cnt_inc == 6'(DEPTH));
               state_d = (cnt_inc == 6'(DEPTH)) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
               if (wr_press) ovf_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 6'd0;
         addr_q  <= '0;
         data_q  <= 8'd0;
         wren_q  <= 1'b0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wren_q  <= wren_d;
         full_q  <= full_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign mem_wren = wren_q;
   assign wr_count = cnt_q;
   assign full     = full_q;
   assign err      = err_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_char_writer.sv
module tb_char_writer;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 5;

   logic              CLOCK = 1'b0;
   logic              RESETn;
   logic [7:0]        SW_CHAR;
   logic              WR_KEYn;
   logic              CLR_KEYn;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_wren;
   logic [5:0]        wr_count;
   logic              full;
   logic              err;
   logic              ovf;

   int vectors    = 0;
   int miscompares = 0;

   // reference model
   int       m_cnt;
   bit       m_err;
   bit       m_ovf;
   int       sup [8] = '{65, 98, 67, 100, 69, 70, 103, 104};

   char_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLOCK    (CLOCK),
      .RESETn   (RESETn),
      .SW_CHAR  (SW_CHAR),
      .WR_KEYn  (WR_KEYn),
      .CLR_KEYn (CLR_KEYn),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wren (mem_wren),
      .wr_count (wr_count),
      .full     (full),
      .err      (err),
      .ovf      (ovf)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   function automatic bit model_sup(input logic [7:0] c);
      foreach (sup[i]) if (int'(c) == sup[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Drives one press window: optional write key, optional clear key (dropped
   // clr_lag cycles after the write key), key held 16 cycles then released.
   // Reports the number of write strobes seen, the first strobe's address,
   // data and latency in cycles from the key drop, and back-to-back strobes.
   task automatic press(input logic [7:0] ch, input bit wr, input bit clr, input int clr_lag,
                        output int nw, output logic [ADDR_W-1:0] a, output logic [7:0] d,
                        output int lat, output int dbl);
      bit prev_w;
      SW_CHAR = ch;
      repeat (3) tick();
      nw = 0; a = '0; d = '0; lat = -1; dbl = 0; prev_w = 1'b0;
      if (wr) WR_KEYn = 1'b0;
      if (clr && clr_lag == 0) CLR_KEYn = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (clr && i == clr_lag) CLR_KEYn = 1'b0;
         if (i == 16) begin WR_KEYn = 1'b1; CLR_KEYn = 1'b1; end
         if (mem_wren === 1'b1) begin
            if (nw == 0) begin a = mem_addr; d = mem_data; lat = i; end
            if (prev_w) dbl++;
            nw++;
         end
         prev_w = (mem_wren === 1'b1);
      end
   endtask

   task automatic do_clear();
      int nw, lat, dbl; logic [ADDR_W-1:0] a; logic [7:0] d;
      press(8'h00, 1'b0, 1'b1, 0, nw, a, d, lat, dbl);
      m_cnt = 0; m_err = 0; m_ovf = 0;
   endtask

   task automatic test_reset();
      RESETn = 1'b1; WR_KEYn = 1'b1; CLR_KEYn = 1'b1; SW_CHAR = 8'd0;
      #2 RESETn = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({mem_wren, mem_addr, mem_data, wr_count, full, err, ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got wren=%b addr=%0d data=%0d cnt=%0d full=%b err=%b ovf=%b, want all 0",
                  mem_wren, mem_addr, mem_data, wr_count, full, err, ovf);
      end
      RESETn = 1'b1;
      repeat (4) tick();
      m_cnt = 0; m_err = 0; m_ovf = 0;
   endtask

   task automatic test_single();
      int nw, lat, dbl; logic [ADDR_W-1:0] a; logic [7:0] d;
      do_clear();
      press(8'd65, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      m_cnt = 1;
      vectors++;
      if (nw !== 1) begin miscompares++; $display("FAIL single_wren_count: got %0d, want 1", nw); end
      vectors++;
      if (a !== 0 || d !== 8'd65) begin miscompares++; $display("FAIL single_addr_data: got %0d/%0d, want 0/65", a, d); end
      // key sampled at edge 1, synchronized pulse after edge 2, strobe after edge 4
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL single_latency: got %0d, want 4", lat); end
      vectors++;
      if (wr_count !== 6'd1) begin miscompares++; $display("FAIL single_wr_count: got %0d, want 1", wr_count); end
   endtask

   task automatic test_fill();
      int nw, lat, dbl; logic [ADDR_W-1:0] a; logic [7:0] d;
      do_clear();
      for (int k = 0; k < 8; k++) begin
         press(8'(sup[k]), 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
         vectors++;
         if (nw !== 1 || a !== ADDR_W'(k) || d !== 8'(sup[k])) begin
            miscompares++;
            $display("FAIL fill_write_%0d: got n=%0d addr=%0d data=%0d, want n=1 addr=%0d data=%0d",
                     k, nw, a, d, k, sup[k]);
         end
      end
      m_cnt = 8;
      vectors++;
      if (full !== 1'b1 || wr_count !== 6'd8) begin
         miscompares++; $display("FAIL fill_full: got full=%b cnt=%0d, want 1/8", full, wr_count);
      end
      press(8'd65, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      m_ovf = 1;
      vectors++;
      if (nw !== 0 || ovf !== 1'b1 || wr_count !== 6'd8 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_overflow: got n=%0d ovf=%b cnt=%0d err=%b, want 0/1/8/0", nw, ovf, wr_count, err);
      end
   endtask

   task automatic test_unsupported();
      int nw, lat, dbl; logic [ADDR_W-1:0] a; logic [7:0] d;
      do_clear();
      press(8'd66, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      vectors++;
      if (nw !== 0 || err !== 1'b1 || wr_count !== 6'd0) begin
         miscompares++; $display("FAIL unsup_66: got n=%0d err=%b cnt=%0d, want 0/1/0", nw, err, wr_count);
      end
      press(8'd67, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      vectors++;
      if (nw !== 1 || a !== 0 || d !== 8'd67 || err !== 1'b1 || wr_count !== 6'd1) begin
         miscompares++;
         $display("FAIL unsup_then_67: got n=%0d addr=%0d data=%0d err=%b cnt=%0d, want 1/0/67/1/1",
                  nw, a, d, err, wr_count);
      end
      m_cnt = 1; m_err = 1;
   endtask

   task automatic test_clear_collide();
      int nw, lat, dbl; logic [ADDR_W-1:0] a; logic [7:0] d;
      do_clear();
      press(8'd66, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      for (int k = 0; k < 3; k++) press(8'(sup[k]), 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      press(8'd65, 1'b1, 1'b1, 0, nw, a, d, lat, dbl);
      m_cnt = 0; m_err = 0; m_ovf = 0;
      vectors++;
      if (nw !== 0 || wr_count !== 6'd0 || err !== 1'b0 || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_with_write: got n=%0d cnt=%0d err=%b ovf=%b, want 0/0/0/0", nw, wr_count, err, ovf);
      end
      // clear press arriving one cycle after the write press lands in WRITE
      press(8'd65, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      press(8'd98, 1'b1, 1'b1, 1, nw, a, d, lat, dbl);
      vectors++;
      if (nw !== 0 || wr_count !== 6'd0) begin
         miscompares++; $display("FAIL clear_in_write: got n=%0d cnt=%0d, want 0/0", nw, wr_count);
      end
   endtask

   task automatic test_reset_in_write();
      int nw, lat, dbl; logic [ADDR_W-1:0] a; logic [7:0] d; int seen;
      do_clear();
      press(8'd65, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      press(8'd98, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      SW_CHAR = 8'd67;
      repeat (3) tick();
      WR_KEYn = 1'b0;
      repeat (3) tick();           // address 2 / data 67 latched, strobe pending
      RESETn = 1'b0;
      #1;
      vectors++;
      if ({mem_wren, mem_addr, mem_data, wr_count, full, err, ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset_in_write: got wren=%b addr=%0d data=%0d cnt=%0d full=%b err=%b ovf=%b, want all 0",
                  mem_wren, mem_addr, mem_data, wr_count, full, err, ovf);
      end
      repeat (2) tick();
      RESETn = 1'b1;
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (mem_wren === 1'b1) seen++;
      end
      vectors++;
      if (seen !== 0 || wr_count !== 6'd0) begin
         miscompares++; $display("FAIL held_key_after_reset: got %0d strobes cnt=%0d, want 0/0", seen, wr_count);
      end
      WR_KEYn = 1'b1;
      repeat (4) tick();
      press(8'd70, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
      vectors++;
      if (nw !== 1 || a !== 0 || d !== 8'd70) begin
         miscompares++; $display("FAIL write_after_reset: got n=%0d addr=%0d data=%0d, want 1/0/70", nw, a, d);
      end
      m_cnt = 1; m_err = 0; m_ovf = 0;
   endtask

   task automatic test_random();
      int nw, lat, dbl, exp_nw, exp_a; logic [ADDR_W-1:0] a; logic [7:0] d; logic [7:0] ch;
      do_clear();
      for (int op = 0; op < 40; op++) begin
         exp_nw = 0; exp_a = 0; ch = 8'd0;
         if ($urandom_range(0, 99) < 12) begin
            press(8'd0, 1'b0, 1'b1, 0, nw, a, d, lat, dbl);
            m_cnt = 0; m_err = 0; m_ovf = 0;
         end else begin
            if ($urandom_range(0, 2) != 0) ch = 8'(sup[$urandom_range(0, 7)]);
            else ch = 8'($urandom);
            if (m_cnt == DEPTH) m_ovf = 1;
            else if (model_sup(ch)) begin exp_nw = 1; exp_a = m_cnt; m_cnt++; end
            else m_err = 1;
            press(ch, 1'b1, 1'b0, 0, nw, a, d, lat, dbl);
         end
         vectors++;
         if (nw !== exp_nw || dbl !== 0 || (exp_nw == 1 && (a !== ADDR_W'(exp_a) || d !== ch))) begin
            miscompares++;
            $display("FAIL rand_write op%0d ch=%0d: got n=%0d dbl=%0d addr=%0d data=%0d, want n=%0d addr=%0d",
                     op, ch, nw, dbl, a, d, exp_nw, exp_a);
         end
         vectors++;
         if (wr_count !== 6'(m_cnt) || full !== (m_cnt == DEPTH) || err !== m_err || ovf !== m_ovf) begin
            miscompares++;
            $display("FAIL rand_status op%0d: got cnt=%0d full=%b err=%b ovf=%b, want %0d/%b/%b/%b",
                     op, wr_count, full, err, ovf, m_cnt, (m_cnt == DEPTH), m_err, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_unsupported();
      test_clear_collide();
      test_reset_in_write();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
